// File: rtl/core_run_ctrl_pkg.sv
// Shared types and constants for the core run controller.
package core_run_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESET_HOLD,
    RUN,
    DONE
  } state_e;

  localparam int unsigned TOHOST_PASS    = 1;
  localparam int unsigned SELFLOOP_LIMIT = 4;

endpackage

// File: rtl/core_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: sequences core reset, runs for a bounded budget, reports pass/fail/timeout.
// Optional PC self-loop detection is built when CORE_RUN_CTRL_SELFLOOP_EN is defined.
//
// state      | meaning
// IDLE       | core held in reset, waiting for start_i
// RESET_HOLD | core reset held low for RESET_CYCLES cycles
// RUN        | core running, end conditions watched
// DONE       | core frozen, results held until the next start_i
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 1024,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_0FFC,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             dmem_we_i,
  input  logic [XLEN-1:0]  dmem_addr_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  output logic             core_rst_n_o,
  output logic             running_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  fail_code_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  state_e     state, state_d;
  logic [7:0] hold_cnt;
  logic       start_clr;
  logic       in_run;
  logic       tohost_hit;
  logic       loop_hit;
  logic       timeout_hit;
  logic       end_run;

  assign start_clr   = start_i && ((state == IDLE) || (state == DONE));
  assign in_run      = (state == RUN);
  assign tohost_hit  = dmem_we_i && (dmem_addr_i == TOHOST_ADDR);
  assign timeout_hit = (cycle_count_o == CNT_W'(MAX_CYCLES - 1));
  assign end_run     = in_run && (tohost_hit || loop_hit || timeout_hit);

  sat_counter #(.W(8)) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (start_clr),
    .en  (state == RESET_HOLD),
    .q   (hold_cnt)
  );

  // The count freezes on the terminating cycle so DONE reports the cycle that ended the run.
  sat_counter #(.W(CNT_W)) u_cycle (
    .clk (clk),
    .rst (rst),
    .clr (start_clr),
    .en  (in_run && !end_run),
    .q   (cycle_count_o)
  );

`ifdef CORE_RUN_CTRL_SELFLOOP_EN
  logic [XLEN-1:0] prev_pc;
  logic [2:0]      loop_cnt;
  logic            pc_match;

  // prev_pc on the first RUN cycle is a reset-hold PC, so that cycle is excluded.
  assign pc_match = in_run && (cycle_count_o != '0) && (pc_i == prev_pc);
  assign loop_hit = pc_match && (loop_cnt == 3'(SELFLOOP_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_pc <= '0;
    else     prev_pc <= pc_i;
  end

  sat_counter #(.W(3)) u_loop (
    .clk (clk),
    .rst (rst),
    .clr (!pc_match),
    .en  (pc_match),
    .q   (loop_cnt)
  );
`else
  logic unused_pc;
  assign unused_pc = ^pc_i;
  assign loop_hit  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:       if (start_i) state_d = RESET_HOLD;
      RESET_HOLD: if (hold_cnt == 8'(RESET_CYCLES - 1)) state_d = RUN;
      RUN:        if (end_run) state_d = DONE;
      DONE:       if (start_i) state_d = RESET_HOLD;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst_n_o <= 1'b0;
      running_o    <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      timeout_o    <= 1'b0;
      fail_code_o  <= '0;
    end else begin
      core_rst_n_o <= (state_d == RUN);
      running_o    <= (state_d == RUN);
      done_o       <= (state_d == DONE);
      if (start_clr) begin
        pass_o      <= 1'b0;
        timeout_o   <= 1'b0;
        fail_code_o <= '0;
      end else if (end_run) begin
        if (tohost_hit) begin
          pass_o      <= (dmem_wdata_i == XLEN'(TOHOST_PASS));
          timeout_o   <= 1'b0;
          fail_code_o <= (dmem_wdata_i == XLEN'(TOHOST_PASS)) ? '0 : dmem_wdata_i;
        end else if (loop_hit) begin
          pass_o      <= 1'b1;
          timeout_o   <= 1'b0;
          fail_code_o <= '0;
        end else begin
          pass_o      <= 1'b0;
          timeout_o   <= 1'b1;
          fail_code_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl with a per-run behavioural scan model.
module tb_core_run_ctrl;

  localparam int          XLEN  = 32;
  localparam int          RC    = 2;
  localparam int          MAXC  = 48;
  localparam int          CNT_W = 32;
  localparam logic [31:0] TH    = 32'h0000_0FFC;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic [XLEN-1:0]  pc_i;
  logic             dmem_we_i;
  logic [XLEN-1:0]  dmem_addr_i;
  logic [XLEN-1:0]  dmem_wdata_i;
  logic             core_rst_n_o;
  logic             running_o;
  logic             done_o;
  logic             pass_o;
  logic             timeout_o;
  logic [XLEN-1:0]  fail_code_o;
  logic [CNT_W-1:0] cycle_count_o;

  int errors = 0;
  int checks = 0;

  core_run_ctrl #(
    .XLEN(XLEN), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .TOHOST_ADDR(TH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pc_i(pc_i),
    .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .core_rst_n_o(core_rst_n_o), .running_o(running_o), .done_o(done_o),
    .pass_o(pass_o), .timeout_o(timeout_o), .fail_code_o(fail_code_o),
    .cycle_count_o(cycle_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run from IDLE/DONE. Cycle indices count RUN cycles from 0; -1 disables an event.
  task automatic do_run(input int decoy_cyc, input logic [31:0] decoy_addr,
                        input logic [31:0] decoy_data, input int th_cyc,
                        input logic [31:0] th_data, input int loop_from);
    logic [31:0] pcs [MAXC];
    logic [31:0] base;
    logic [31:0] a;
    int          end_k;
    int          streak;
    logic        e_pass;
    logic        e_to;
    logic [31:0] e_fc;

    base = $urandom & 32'h0FFF_FFFC;
    for (int k = 0; k < MAXC; k++)
      pcs[k] = (loop_from >= 0 && k >= loop_from) ? 32'h40 : base + 32'(4 * k);

    // Scan the run cycle by cycle applying the end rules in priority order.
    end_k = MAXC - 1; e_pass = 1'b0; e_to = 1'b1; e_fc = '0; streak = 0;
    for (int k = 0; k < MAXC; k++) begin
      if (k > 0 && pcs[k] == pcs[k-1]) streak++;
      else streak = 0;
      if (k == th_cyc) begin
        end_k = k; e_to = 1'b0; e_pass = (th_data == 32'd1);
        e_fc = e_pass ? 32'd0 : th_data;
        break;
      end
`ifdef CORE_RUN_CTRL_SELFLOOP_EN
      if (streak >= 4) begin
        end_k = k; e_to = 1'b0; e_pass = 1'b1; e_fc = '0;
        break;
      end
`endif
    end

    start_i = 1'b1;
    pc_i    = base - 32'd4;
    step();
    start_i = 1'b0;
    for (int h = 0; h < RC; h++) begin
      chk("hold_core_rst_n", core_rst_n_o, 0);
      chk("hold_running", running_o, 0);
      chk("hold_done", done_o, 0);
      start_i = 1'($urandom_range(0, 1));
      step();
    end

    for (int k = 0; k <= end_k; k++) begin
      chk("run_core_rst_n", core_rst_n_o, 1);
      chk("run_running", running_o, 1);
      chk("run_count", cycle_count_o, 64'(k));
      pc_i    = pcs[k];
      start_i = ($urandom_range(0, 7) == 0);
      if (k == th_cyc) begin
        dmem_we_i = 1'b1; dmem_addr_i = TH; dmem_wdata_i = th_data;
      end else if (k == decoy_cyc) begin
        dmem_we_i = 1'b1; dmem_addr_i = decoy_addr; dmem_wdata_i = decoy_data;
      end else begin
        a = $urandom;
        if (a == TH) a = a ^ 32'd4;
        dmem_we_i = ($urandom_range(0, 3) == 0); dmem_addr_i = a; dmem_wdata_i = $urandom;
      end
      step();
    end
    dmem_we_i = 1'b0;
    start_i   = 1'b0;

    chk("done", done_o, 1);
    chk("done_running", running_o, 0);
    chk("done_core_rst_n", core_rst_n_o, 0);
    chk("pass", pass_o, 64'(e_pass));
    chk("timeout", timeout_o, 64'(e_to));
    chk("fail_code", fail_code_o, 64'(e_fc));
    chk("done_count", cycle_count_o, 64'(end_k));
    step();
    step();
    chk("done_hold", done_o, 1);
    chk("done_hold_count", cycle_count_o, 64'(end_k));
    chk("done_hold_pass", pass_o, 64'(e_pass));
  endtask

  initial begin
    int th;
    int lf;
    logic [31:0] d;

    rst = 1'b1; start_i = 1'b0; pc_i = '0;
    dmem_we_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0;
    repeat (3) step();
    chk("rst_core_rst_n", core_rst_n_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_running", running_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_count", cycle_count_o, 0);
    rst = 1'b0;
    repeat (5) step();
    chk("idle_core_rst_n", core_rst_n_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_running", running_o, 0);

    do_run(-1, 0, 0, 37, 32'd1, -1);
    do_run(5, 32'h0000_0FF8, 32'd1, 20, 32'd7, -1);
    do_run(-1, 0, 0, -1, 0, -1);
    do_run(-1, 0, 0, MAXC - 1, 32'd1, -1);

    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (RC + 10) step();
    chk("pre_rst_running", running_o, 1);
    rst = 1'b1;
    #1;
    chk("midrst_core_rst_n", core_rst_n_o, 0);
    chk("midrst_running", running_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_count", cycle_count_o, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_idle", running_o, 0);
    chk("post_rst_core_rst_n", core_rst_n_o, 0);

    do_run(-1, 0, 0, $urandom_range(3, 40), $urandom | 32'h2, -1);
    do_run(-1, 0, 0, -1, 0, 10);
    do_run(-1, 0, 0, 30, 32'd1, 0);

    for (int i = 0; i < 4; i++) begin
      th = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXC - 1)) : -1;
      d  = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
      lf = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXC - 1)) : -1;
      do_run(int'($urandom_range(0, MAXC - 1)), 32'h0000_0FF8, 32'd1, th, d, lf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
